// File: rtl/matvec_core_if.sv
// matvec_core_if: command, memory-element and row-result handshakes of matvec_core.
// The master side issues commands, streams elements and accepts results.
interface matvec_core_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 18
);
    logic                  cmd_vld;
    logic                  cmd_rdy;
    logic [1:0]            cmd_op;
    logic                  in_vld;
    logic                  in_rdy;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_vld;
    logic                  out_rdy;
    logic [ACC_WIDTH-1:0]  out_data;

    modport master (
        output cmd_vld, cmd_op, in_vld, in_data, out_rdy,
        input  cmd_rdy, in_rdy, out_vld, out_data
    );

    modport slave (
        input  cmd_vld, cmd_op, in_vld, in_data, out_rdy,
        output cmd_rdy, in_rdy, out_vld, out_data
    );
endinterface

// File: rtl/matvec_core.sv
// matvec_core: loads W and x from the memory stream, computes y = W*x one MAC per cycle.
// Optional MATVEC_RELU_EN clamps negative row results to zero at the output only.
module matvec_core #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAT_DIM    = 4,
    parameter int unsigned ACC_WIDTH  = 18
) (
    input  logic         clk,
    input  logic         rst,
    matvec_core_if.slave bus,
    output logic         busy
);
    localparam int unsigned W_ELEMS = MAT_DIM * MAT_DIM;
    localparam int unsigned IDX_W   = (W_ELEMS > 1) ? $clog2(W_ELEMS) : 1;
    localparam int unsigned DIM_W   = (MAT_DIM > 1) ? $clog2(MAT_DIM) : 1;
    localparam int unsigned PROD_W  = 2 * DATA_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_LOAD_X, S_MAC, S_DRAIN} state_t;

    state_t state, state_nxt;

    logic signed [DATA_WIDTH-1:0] w_mem [W_ELEMS];
    logic signed [DATA_WIDTH-1:0] x_mem [MAT_DIM];

    logic [IDX_W-1:0]            idx, idx_nxt, w_idx;
    logic [DIM_W-1:0]            row, row_nxt, col, col_nxt;
    logic signed [ACC_WIDTH-1:0] acc, acc_nxt;
    logic signed [PROD_W-1:0]    prod;

    logic                 cmd_rdy_q, in_rdy_q, out_vld_q, busy_q;
    logic                 cmd_rdy_nxt, in_rdy_nxt, out_vld_nxt, busy_nxt;
    logic [ACC_WIDTH-1:0] out_data_q, out_data_nxt;

    logic cmd_fire, in_fire, out_fire;

    assign cmd_fire = bus.cmd_vld && cmd_rdy_q;
    assign in_fire  = bus.in_vld && in_rdy_q;
    assign out_fire = out_vld_q && bus.out_rdy;

    assign w_idx = IDX_W'(row) * IDX_W'(MAT_DIM) + IDX_W'(col);
    assign prod  = w_mem[w_idx] * x_mem[col];

    // State, counters, accumulator and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            row        <= '0;
            col        <= '0;
            acc        <= '0;
            cmd_rdy_q  <= 1'b1;
            in_rdy_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            busy_q     <= 1'b0;
            out_data_q <= '0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            row        <= row_nxt;
            col        <= col_nxt;
            acc        <= acc_nxt;
            cmd_rdy_q  <= cmd_rdy_nxt;
            in_rdy_q   <= in_rdy_nxt;
            out_vld_q  <= out_vld_nxt;
            busy_q     <= busy_nxt;
            out_data_q <= out_data_nxt;
        end
    end

    // Operand storage; in_rdy is only high in the two load states
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(W_ELEMS); i++) w_mem[i] <= '0;
            for (int i = 0; i < int'(MAT_DIM); i++) x_mem[i] <= '0;
        end else if (in_fire) begin
            if (state == S_LOAD_W) w_mem[idx] <= bus.in_data;
            else                   x_mem[DIM_W'(idx)] <= bus.in_data;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        row_nxt   = row;
        col_nxt   = col;
        acc_nxt   = acc;
        case (state)
            S_IDLE: begin
                if (cmd_fire) begin
                    idx_nxt = '0;
                    case (bus.cmd_op)
                        2'd0: state_nxt = S_LOAD_W;
                        2'd1: state_nxt = S_LOAD_X;
                        2'd2: begin
                            state_nxt = S_MAC;
                            row_nxt   = '0;
                            col_nxt   = '0;
                            acc_nxt   = '0;
                        end
                        default: state_nxt = S_IDLE;
                    endcase
                end
            end
            S_LOAD_W, S_LOAD_X: begin
                if (in_fire) begin
                    if ((state == S_LOAD_W && idx == IDX_W'(W_ELEMS - 1)) ||
                        (state == S_LOAD_X && idx == IDX_W'(MAT_DIM - 1))) begin
                        state_nxt = S_IDLE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            S_MAC: begin
                acc_nxt = acc + ACC_WIDTH'(prod);
                if (col == DIM_W'(MAT_DIM - 1)) begin
                    state_nxt = S_DRAIN;
                    col_nxt   = '0;
                end else begin
                    col_nxt = col + DIM_W'(1);
                end
            end
            S_DRAIN: begin
                if (out_fire) begin
                    if (row == DIM_W'(MAT_DIM - 1)) begin
                        state_nxt = S_IDLE;
                        row_nxt   = '0;
                    end else begin
                        state_nxt = S_MAC;
                        row_nxt   = row + DIM_W'(1);
                        col_nxt   = '0;
                        acc_nxt   = '0;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode of the next state, registered above
    always_comb begin
        cmd_rdy_nxt  = (state_nxt == S_IDLE);
        in_rdy_nxt   = (state_nxt == S_LOAD_W) || (state_nxt == S_LOAD_X);
        out_vld_nxt  = (state_nxt == S_DRAIN);
        busy_nxt     = (state_nxt != S_IDLE);
        out_data_nxt = acc_nxt;
`ifdef MATVEC_RELU_EN
        if (acc_nxt[ACC_WIDTH-1]) out_data_nxt = '0;
`endif
    end

    assign bus.cmd_rdy  = cmd_rdy_q;
    assign bus.in_rdy   = in_rdy_q;
    assign bus.out_vld  = out_vld_q;
    assign bus.out_data = out_data_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_matvec_core.sv
// tb_matvec_core: directed scenario tasks for matvec_core with hand-computed expectations.
module tb_matvec_core;
    localparam int unsigned DW = 8;
    localparam int unsigned MD = 4;
    localparam int unsigned AW = 18;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    matvec_core_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();

    matvec_core #(.DATA_WIDTH(DW), .MAT_DIM(MD), .ACC_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op);
        bus.cmd_vld = 1'b1;
        bus.cmd_op  = op;
        tick();
        bus.cmd_vld = 1'b0;
        bus.cmd_op  = 2'd0;
    endtask

    task automatic load_w(input logic [DW-1:0] v [MD*MD]);
        send_cmd(2'd0);
        foreach (v[i]) begin
            bus.in_vld  = 1'b1;
            bus.in_data = v[i];
            tick();
        end
        bus.in_vld = 1'b0;
    endtask

    task automatic load_x(input logic [DW-1:0] v [MD]);
        send_cmd(2'd1);
        foreach (v[i]) begin
            bus.in_vld  = 1'b1;
            bus.in_data = v[i];
            tick();
        end
        bus.in_vld = 1'b0;
    endtask

    // COMPUTE with out_rdy held high; cycle numbers count edges after the command edge
    task automatic run_compute(output logic [AW-1:0] res [MD], output int first_vld,
                               output int done_cyc, output int nres);
        nres      = 0;
        first_vld = -1;
        done_cyc  = -1;
        foreach (res[i]) res[i] = '0;
        bus.out_rdy = 1'b1;
        send_cmd(2'd2);
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (bus.out_vld) begin
                if (first_vld < 0) first_vld = cyc;
                if (nres < int'(MD)) res[nres] = bus.out_data;
                nres++;
            end
            if (nres >= int'(MD) && !busy) begin
                done_cyc = cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        logic [AW-1:0] res [MD];
        int fv, dc, nr;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.cmd_rdy !== 1'b1 || bus.in_rdy !== 1'b0 || bus.out_vld !== 1'b0 ||
            bus.out_data !== 18'd0 || busy !== 1'b0)
            $display("FAIL reset_outputs: got cmd_rdy=%b in_rdy=%b out_vld=%b out_data=%0d busy=%b expected 1 0 0 0 0",
                     bus.cmd_rdy, bus.in_rdy, bus.out_vld, bus.out_data, busy);
        if (bus.cmd_rdy !== 1'b1 || bus.in_rdy !== 1'b0 || bus.out_vld !== 1'b0 ||
            bus.out_data !== 18'd0 || busy !== 1'b0) errors++;
        rst = 1'b0;
        tick();
        send_cmd(2'd3);
        checks++;
        if (busy !== 1'b0 || bus.cmd_rdy !== 1'b1 || bus.in_rdy !== 1'b0) begin
            errors++;
            $display("FAIL reserved_op: got busy=%b cmd_rdy=%b in_rdy=%b expected 0 1 0",
                     busy, bus.cmd_rdy, bus.in_rdy);
        end
        run_compute(res, fv, dc, nr);
        checks++;
        if (nr !== int'(MD) || dc < 0) begin
            errors++;
            $display("FAIL zero_compute_count: got %0d results done=%0d expected %0d results", nr, dc, MD);
        end
        for (int i = 0; i < int'(MD); i++) begin
            checks++;
            if (res[i] !== 18'd0) begin
                errors++;
                $display("FAIL zero_compute_row%0d: got %0d expected 0", i, $signed(res[i]));
            end
        end
    endtask

    task automatic test_identity();
        logic [DW-1:0] w [MD*MD];
        logic [DW-1:0] x [MD];
        logic [AW-1:0] res [MD];
        logic [AW-1:0] exp_v [MD];
        int fv, dc, nr;
        foreach (w[i]) w[i] = ((i / MD) == (i % MD)) ? 8'd1 : 8'd0;
        x     = '{8'd1, 8'd2, 8'd3, 8'd4};
        exp_v = '{18'd1, 18'd2, 18'd3, 18'd4};
        load_w(w);
        load_x(x);
        run_compute(res, fv, dc, nr);
        checks++;
        if (nr !== 4) begin
            errors++;
            $display("FAIL identity_count: got %0d expected 4", nr);
        end
        checks++;
        if (fv !== 4) begin
            errors++;
            $display("FAIL identity_first_vld: got cycle %0d expected 4", fv);
        end
        checks++;
        if (dc !== 20) begin
            errors++;
            $display("FAIL identity_busy_fall: got cycle %0d expected 20", dc);
        end
        for (int i = 0; i < int'(MD); i++) begin
            checks++;
            if (res[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL identity_row%0d: got %0d expected %0d", i, $signed(res[i]), exp_v[i]);
            end
        end
    endtask

    task automatic test_max_pos();
        logic [DW-1:0] w [MD*MD];
        logic [DW-1:0] x [MD];
        logic [AW-1:0] res [MD];
        int fv, dc, nr;
        foreach (w[i]) w[i] = 8'd127;
        foreach (x[i]) x[i] = 8'd127;
        load_w(w);
        load_x(x);
        run_compute(res, fv, dc, nr);
        for (int i = 0; i < int'(MD); i++) begin
            checks++;
            if (res[i] !== 18'd64516) begin
                errors++;
                $display("FAIL max_pos_row%0d: got %0d expected 64516", i, $signed(res[i]));
            end
        end
    endtask

    task automatic test_negative();
        logic [DW-1:0] w [MD*MD];
        logic [DW-1:0] x [MD];
        logic [AW-1:0] res [MD];
        logic [AW-1:0] exp_neg;
        int fv, dc, nr;
`ifdef MATVEC_RELU_EN
        exp_neg = 18'd0;
`else
        exp_neg = 18'h30200;
`endif
        foreach (w[i]) w[i] = 8'h80;
        foreach (x[i]) x[i] = 8'd127;
        load_w(w);
        load_x(x);
        run_compute(res, fv, dc, nr);
        for (int i = 0; i < int'(MD); i++) begin
            checks++;
            if (res[i] !== exp_neg) begin
                errors++;
                $display("FAIL negative_row%0d: got %0d expected %0d", i, $signed(res[i]), $signed(exp_neg));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] w [MD*MD];
        logic [DW-1:0] x [MD];
        logic [AW-1:0] exp_v [MD];
        int cyc;
        foreach (w[i]) w[i] = 8'd0;
        for (int i = 0; i < 4; i++) w[i] = 8'd1;
        for (int i = 0; i < 4; i++) w[4 + i] = 8'(i + 1);
        foreach (x[i]) x[i] = 8'd2;
        exp_v = '{18'd8, 18'd20, 18'd0, 18'd0};
        load_w(w);
        load_x(x);
        bus.out_rdy = 1'b0;
        send_cmd(2'd2);
        cyc = 0;
        while (!bus.out_vld && cyc < 50) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc !== 4) begin
            errors++;
            $display("FAIL bp_first_vld: got cycle %0d expected 4", cyc);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.out_vld !== 1'b1 || bus.out_data !== 18'd8) begin
                errors++;
                $display("FAIL bp_hold%0d: got vld=%b data=%0d expected vld=1 data=8", i, bus.out_vld, bus.out_data);
            end
            tick();
        end
        bus.out_rdy = 1'b1;
        tick();
        checks++;
        if (bus.out_vld !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got vld=%b busy=%b expected vld=0 busy=1", bus.out_vld, busy);
        end
        for (int r = 1; r < int'(MD); r++) begin
            cyc = 0;
            while (!bus.out_vld && cyc < 50) begin
                tick();
                cyc++;
            end
            checks++;
            if (bus.out_vld !== 1'b1 || bus.out_data !== exp_v[r]) begin
                errors++;
                $display("FAIL bp_row%0d: got vld=%b data=%0d expected vld=1 data=%0d", r, bus.out_vld, bus.out_data, exp_v[r]);
            end
            if (r == 1) begin
                checks++;
                if (cyc !== 4) begin
                    errors++;
                    $display("FAIL bp_row1_latency: got %0d cycles expected 4", cyc);
                end
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0 || bus.cmd_rdy !== 1'b1) begin
            errors++;
            $display("FAIL bp_end_idle: got busy=%b cmd_rdy=%b expected 0 1", busy, bus.cmd_rdy);
        end
    endtask

    task automatic test_stall_stray();
        logic [DW-1:0] x [MD];
        logic [AW-1:0] res [MD];
        logic [AW-1:0] exp_v [MD];
        int fv, dc, nr;
        foreach (x[i]) x[i] = 8'd1;
        exp_v = '{18'd10, 18'd26, 18'd42, 18'd58};
        load_x(x);
        send_cmd(2'd0);
        for (int i = 0; i < 7; i++) begin
            bus.in_vld  = 1'b1;
            bus.in_data = 8'(i + 1);
            tick();
        end
        bus.in_vld  = 1'b0;
        bus.in_data = 8'h55;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.in_rdy !== 1'b1 || busy !== 1'b1 || bus.cmd_rdy !== 1'b0) begin
                errors++;
                $display("FAIL stall_cycle%0d: got in_rdy=%b busy=%b cmd_rdy=%b expected 1 1 0",
                         i, bus.in_rdy, busy, bus.cmd_rdy);
            end
            tick();
        end
        for (int i = 7; i < 16; i++) begin
            bus.in_vld  = 1'b1;
            bus.in_data = 8'(i + 1);
            tick();
        end
        bus.in_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_vld  = 1'b1;
            bus.in_data = 8'h7f;
            tick();
            checks++;
            if (bus.in_rdy !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL stray_idle%0d: got in_rdy=%b busy=%b expected 0 0", i, bus.in_rdy, busy);
            end
        end
        bus.in_vld = 1'b0;
        run_compute(res, fv, dc, nr);
        for (int i = 0; i < int'(MD); i++) begin
            checks++;
            if (res[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL stall_row%0d: got %0d expected %0d", i, $signed(res[i]), exp_v[i]);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [DW-1:0] x [MD];
        logic [AW-1:0] res [MD];
        int fv, dc, nr;
        send_cmd(2'd0);
        for (int i = 0; i < 7; i++) begin
            bus.in_vld  = 1'b1;
            bus.in_data = 8'd9;
            tick();
        end
        bus.in_vld = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.cmd_rdy !== 1'b1 || bus.in_rdy !== 1'b0 || busy !== 1'b0 || bus.out_vld !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_load: got cmd_rdy=%b in_rdy=%b busy=%b out_vld=%b expected 1 0 0 0",
                     bus.cmd_rdy, bus.in_rdy, busy, bus.out_vld);
        end
        foreach (x[i]) x[i] = 8'd1;
        load_x(x);
        run_compute(res, fv, dc, nr);
        for (int i = 0; i < int'(MD); i++) begin
            checks++;
            if (res[i] !== 18'd0) begin
                errors++;
                $display("FAIL rst_mid_load_row%0d: got %0d expected 0", i, $signed(res[i]));
            end
        end
    endtask

    initial begin
        bus.cmd_vld = 1'b0;
        bus.cmd_op  = 2'd0;
        bus.in_vld  = 1'b0;
        bus.in_data = '0;
        bus.out_rdy = 1'b0;
        rst         = 1'b1;
        test_reset();
        test_identity();
        test_max_pos();
        test_negative();
        test_backpressure();
        test_stall_stray();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
